bsmac_seq: RTL

Sequencer for the binary-serial MAC accumulator in each systolic PE: it accepts one MAC job per handshake and drives the accumulator's `en`/`clr`/`mac_done` controls. It also drives the weight-bit select and sign-bit flag into the bit-serial product stage, walking the weight MSB first for a configurable number of bits. After the serial phase it issues one fold cycle, which adds the upstream partial sum to the accumulated product. It then holds the result under a valid/ready handshake toward the downstream PE.

---
 rtl/bsmac_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/bsmac_seq.sv
// Sequencer for the bit-serial MAC accumulator of a systolic PE: it runs CLR, then n
// serial bit cycles (MSB first), then one fold cycle, and holds the result under valid/ready.
module bsmac_seq #(
   parameter int BITW = 8,
   parameter int SELW = $clog2(BITW),
   parameter int NBW  = $clog2(BITW) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            ready,
   input  logic [NBW-1:0]  nbits,
   input  logic            abort,
   output logic            acc_en,
   output logic            acc_clr,
   output logic            acc_mac_done,
   output logic [SELW-1:0] bit_sel,
   output logic            bit_msb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, CLR, SER, FOLD, HOLD} state_t;

   localparam logic [NBW-1:0] BITW_N = NBW'(BITW);

   state_t          state, state_nx;
   logic [SELW-1:0] cnt, cnt_nx;
   logic [NBW-1:0]  n_lat, n_nx, n_eff, n_m1;

   // A zero or oversized bit count falls back to the full weight width.
   assign n_eff = (nbits == '0 || nbits > BITW_N) ? BITW_N : nbits;
   assign n_m1  = n_lat - NBW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         n_lat <= BITW_N;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         n_lat <= n_nx;
      end
   end

   // Next state; abort outranks everything once a job is in flight.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      n_nx     = n_lat;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = CLR;
               n_nx     = n_eff;
            end
         end
         CLR: begin
            state_nx = SER;
            cnt_nx   = n_m1[SELW-1:0];
         end
         SER: begin
            if (cnt == '0) state_nx = FOLD;
            else           cnt_nx   = cnt - SELW'(1);
         end
         FOLD: state_nx = HOLD;
         HOLD: begin
            if (out_ready) begin
               if (start) begin
                  state_nx = CLR;
                  n_nx     = n_eff;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_nx = IDLE;
         cnt_nx   = cnt;
         n_nx     = n_lat;
      end
   end

   // Moore outputs; the only input-dependent term is ready mirroring out_ready in HOLD.
   always_comb begin
      ready        = 1'b0;
      acc_en       = 1'b0;
      acc_clr      = 1'b0;
      acc_mac_done = 1'b0;
      bit_sel      = '0;
      bit_msb      = 1'b0;
      out_valid    = 1'b0;
      busy         = (state != IDLE);
      case (state)
         IDLE: ready = 1'b1;
         CLR:  acc_clr = 1'b1;
         SER: begin
            acc_en  = 1'b1;
            bit_sel = cnt;
            bit_msb = ({1'b0, cnt} == n_m1);
         end
         FOLD: begin
            acc_en       = 1'b1;
            acc_mac_done = 1'b1;
         end
         HOLD: begin
            out_valid = 1'b1;
            ready     = out_ready;
         end
         default: ;
      endcase
   end

endmodule
